// File: rtl/bdu_scheduler.sv
// rtl/bdu_scheduler.sv - query/reference bit-serial sequencer for one BDU; BDU_SCHED_EARLY_TERM_EN enables early-termination abort
module bdu_scheduler #(
  parameter int B     = 32,
  parameter int IDX_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 q_load,
  input  logic [B-1:0]         q_x,
  input  logic [B-1:0]         q_y,
  input  logic [B-1:0]         q_z,
  input  logic [B-1:0]         thr_in,
  input  logic                 ref_valid,
  output logic                 ref_ready,
  input  logic [B-1:0]         ref_x,
  input  logic [B-1:0]         ref_y,
  input  logic [B-1:0]         ref_z,
  input  logic [IDX_W-1:0]     ref_idx,
  output logic                 bdu_clr,
  output logic                 bdu_valid,
  output logic                 bdu_q_bit,
  output logic                 bdu_r_bit,
  output logic [1:0]           bdu_code,
  output logic [$clog2(B)-1:0] bdu_b,
  output logic [B-1:0]         bdu_threshold,
  input  logic                 bdu_terminate,
  input  logic                 bdu_done,
  input  logic [B-1:0]         bdu_dist,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDX_W-1:0]     res_idx,
  output logic [B-1:0]         res_dist,
  output logic                 res_pruned,
  output logic                 busy
);

  localparam int KW = $clog2(B);
  localparam logic [KW-1:0] K_LAST = KW'(B - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESULT} state_t;
  state_t state, state_nx;

  logic [B-1:0]     qx_r, qy_r, qz_r, thr_r;
  logic [B-1:0]     rx_r, ry_r, rz_r, dist_r;
  logic [IDX_W-1:0] idx_r;
  logic             q_loaded, pruned_r, sticky_r;
  logic [KW-1:0]    k_r;
  logic [1:0]       c_r;
  logic             ld_query, ld_ref, ld_res, pruned_nx, set_sticky, last_bit;
  logic [KW-1:0]    bit_sel;

  assign ref_ready = (state == IDLE) && q_loaded && !q_load;
  assign last_bit  = (c_r == 2'd3) && (k_r == K_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    ld_query   = 1'b0;
    ld_ref     = 1'b0;
    ld_res     = 1'b0;
    pruned_nx  = 1'b0;
    set_sticky = 1'b0;
    case (state)
      IDLE: begin
        if (q_load) begin
          ld_query = 1'b1;
        end else if (ref_valid && ref_ready) begin
          ld_ref   = 1'b1;
          state_nx = CLEAR;
        end
      end
      CLEAR: state_nx = STREAM;
      STREAM: begin
`ifdef BDU_SCHED_EARLY_TERM_EN
        if (bdu_terminate) begin
          ld_res    = 1'b1;
          pruned_nx = 1'b1;
          state_nx  = RESULT;
        end else if (last_bit) begin
          state_nx = DRAIN;
        end
`else
        // terminate is only remembered here; the full stream always runs
        set_sticky = bdu_terminate;
        if (last_bit) state_nx = DRAIN;
`endif
      end
      DRAIN: begin
        if (bdu_done || bdu_terminate) begin
          ld_res    = 1'b1;
          pruned_nx = bdu_terminate || sticky_r;
          state_nx  = RESULT;
        end
      end
      RESULT: if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qx_r     <= '0;
      qy_r     <= '0;
      qz_r     <= '0;
      thr_r    <= '0;
      q_loaded <= 1'b0;
      rx_r     <= '0;
      ry_r     <= '0;
      rz_r     <= '0;
      idx_r    <= '0;
      k_r      <= '0;
      c_r      <= 2'd0;
      sticky_r <= 1'b0;
      dist_r   <= '0;
      pruned_r <= 1'b0;
    end else begin
      if (ld_query) begin
        qx_r     <= q_x;
        qy_r     <= q_y;
        qz_r     <= q_z;
        thr_r    <= thr_in;
        q_loaded <= 1'b1;
      end
      if (ld_ref) begin
        rx_r  <= ref_x;
        ry_r  <= ref_y;
        rz_r  <= ref_z;
        idx_r <= ref_idx;
      end
      if (state == CLEAR) begin
        k_r      <= '0;
        c_r      <= 2'd1;
        sticky_r <= 1'b0;
      end else if (state == STREAM) begin
        if (c_r == 2'd3) begin
          c_r <= 2'd1;
          k_r <= k_r + KW'(1);
        end else begin
          c_r <= c_r + 2'd1;
        end
        if (set_sticky) sticky_r <= 1'b1;
      end
      if (ld_res) begin
        dist_r   <= bdu_dist;
        pruned_r <= pruned_nx;
      end
    end
  end

  // k counts from the MSB, so the bit position is the complement within B
  assign bit_sel = K_LAST - k_r;

  always_comb begin
    bdu_q_bit = 1'b0;
    bdu_r_bit = 1'b0;
    bdu_code  = 2'd0;
    bdu_b     = '0;
    if (state == STREAM) begin
      bdu_code = c_r;
      bdu_b    = k_r + KW'(1);
      case (c_r)
        2'd1: begin bdu_q_bit = qx_r[bit_sel]; bdu_r_bit = rx_r[bit_sel]; end
        2'd2: begin bdu_q_bit = qy_r[bit_sel]; bdu_r_bit = ry_r[bit_sel]; end
        2'd3: begin bdu_q_bit = qz_r[bit_sel]; bdu_r_bit = rz_r[bit_sel]; end
        default: begin bdu_q_bit = 1'b0; bdu_r_bit = 1'b0; end
      endcase
    end
  end

  assign bdu_clr       = (state == CLEAR);
  assign bdu_valid     = (state == STREAM);
  assign bdu_threshold = thr_r;
  assign res_valid     = (state == RESULT);
  assign res_idx       = idx_r;
  assign res_dist      = dist_r;
  assign res_pruned    = pruned_r;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_bdu_scheduler.sv
// tb/tb_bdu_scheduler.sv - randomized scoreboard bench for bdu_scheduler with a behavioural BDU stub
module tb_bdu_scheduler;
  localparam int B       = 32;
  localparam int IDX_W   = 16;
  localparam int KW      = $clog2(B);
  localparam int T       = 3 * B;
  localparam int NO_TERM = 100000;

  logic             clk = 1'b0;
  logic             rst;
  logic             q_load;
  logic [B-1:0]     q_x, q_y, q_z, thr_in;
  logic             ref_valid, ref_ready;
  logic [B-1:0]     ref_x, ref_y, ref_z;
  logic [IDX_W-1:0] ref_idx;
  logic             bdu_clr, bdu_valid, bdu_q_bit, bdu_r_bit;
  logic [1:0]       bdu_code;
  logic [KW-1:0]    bdu_b;
  logic [B-1:0]     bdu_threshold;
  logic             bdu_terminate, bdu_done;
  logic [B-1:0]     bdu_dist;
  logic             res_valid, res_ready;
  logic [IDX_W-1:0] res_idx;
  logic [B-1:0]     res_dist;
  logic             res_pruned, busy;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bdu_scheduler #(.B(B), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .q_load(q_load), .q_x(q_x), .q_y(q_y), .q_z(q_z), .thr_in(thr_in),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_x(ref_x), .ref_y(ref_y), .ref_z(ref_z),
    .ref_idx(ref_idx), .bdu_clr(bdu_clr), .bdu_valid(bdu_valid), .bdu_q_bit(bdu_q_bit),
    .bdu_r_bit(bdu_r_bit), .bdu_code(bdu_code), .bdu_b(bdu_b), .bdu_threshold(bdu_threshold),
    .bdu_terminate(bdu_terminate), .bdu_done(bdu_done), .bdu_dist(bdu_dist),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_dist(res_dist),
    .res_pruned(res_pruned), .busy(busy)
  );

  typedef struct {
    logic [B-1:0]     qx, qy, qz, thr, rx, ry, rz, base;
    logic [IDX_W-1:0] idx;
    int               term_at, done_delay;
    bit               drain_term, stall;
    int               e_nbits, e_lat, acc_cyc;
    logic [B-1:0]     e_dist;
    bit               e_pruned;
  } pt_t;

  pt_t exp_q[$];
  pt_t stub_q[$];
  int total = 0;
  int bad = 0;
  logic [B-1:0] mqx, mqy, mqz, mthr;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic abort_run(input string name);
    total++;
    bad++;
    $display("FAIL %s: no response within cycle budget", name);
    finish_run();
  endtask

  // Expected outcome from the stub's scripted behaviour: dist is base+stream index, or base+3B+drain index
  function automatic pt_t predict(input pt_t p);
    pt_t r = p;
    r.e_nbits  = T;
    r.e_dist   = p.base + B'(T + p.done_delay);
    r.e_pruned = p.drain_term || (p.term_at < T);
    r.e_lat    = T + 3 + p.done_delay;
`ifdef BDU_SCHED_EARLY_TERM_EN
    if (p.term_at < T) begin
      r.e_nbits  = p.term_at + 1;
      r.e_dist   = p.base + B'(p.term_at);
      r.e_pruned = 1'b1;
      r.e_lat    = p.term_at + 3;
    end
`endif
    return r;
  endfunction

  function automatic pt_t rand_pt();
    pt_t p;
    p.qx = '0; p.qy = '0; p.qz = '0; p.thr = '0;
    p.rx = B'($urandom); p.ry = B'($urandom); p.rz = B'($urandom);
    p.idx = IDX_W'($urandom);
    p.base = B'($urandom);
    p.term_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, T - 1)) : NO_TERM;
    p.done_delay = int'($urandom_range(0, 3));
    p.drain_term = ($urandom_range(0, 4) == 0);
    p.stall = ($urandom_range(0, 5) == 0);
    p.e_nbits = 0; p.e_lat = 0; p.acc_cyc = 0; p.e_dist = '0; p.e_pruned = 1'b0;
    return p;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    abort_run("wait_idle");
  endtask

  task automatic load_query(input logic [B-1:0] x, input logic [B-1:0] y, input logic [B-1:0] z, input logic [B-1:0] t);
    @(negedge clk);
    q_load = 1'b1; q_x = x; q_y = y; q_z = z; thr_in = t;
    mqx = x; mqy = y; mqz = z; mthr = t;
    @(negedge clk);
    q_load = 1'b0;
  endtask

  task automatic send_point(input pt_t p, input bit collide, input bit junk);
    int n;
    int maxn;
    @(negedge clk);
    ref_valid = 1'b1; ref_x = p.rx; ref_y = p.ry; ref_z = p.rz; ref_idx = p.idx;
    if (collide) begin
      q_load = 1'b1;
      q_x = B'($urandom); q_y = B'($urandom); q_z = B'($urandom); thr_in = B'($urandom);
      mqx = q_x; mqy = q_y; mqz = q_z; mthr = thr_in;
      #1;
      chk("collide_ref_ready", ref_ready, 1'b0);
      @(negedge clk);
      q_load = 1'b0;
    end
    for (n = 0; n < 3000; n++) begin
      #1;
      if (ref_ready) break;
      @(negedge clk);
    end
    if (!ref_ready) abort_run("ref_accept");
    p.qx = mqx; p.qy = mqy; p.qz = mqz; p.thr = mthr;
    p.acc_cyc = cyc;
    p = predict(p);
    exp_q.push_back(p);
    stub_q.push_back(p);
    @(negedge clk);
    ref_valid = 1'b0;
    if (junk) begin
      maxn = T;
`ifdef BDU_SCHED_EARLY_TERM_EN
      if (p.term_at < T) maxn = p.term_at + 1;
`endif
      n = int'($urandom_range(1, maxn));
      repeat (n) @(negedge clk);
      q_load = 1'b1;
      q_x = B'($urandom); q_y = B'($urandom); q_z = B'($urandom); thr_in = B'($urandom);
      @(negedge clk);
      q_load = 1'b0;
    end
  endtask

  // BDU stub plus bit-stream checker
  initial begin
    int s, d, k, co;
    bit was;
    pt_t cur;
    logic qb, rb;
    logic [B+KW+3:0] want;
    s = 0; d = 0; was = 1'b0;
    forever @(negedge clk) begin
      if (!rst) begin
        bdu_terminate = 1'b0; bdu_done = 1'b0; bdu_dist = '0;
        s = 0; d = 0; was = 1'b0;
      end else if (bdu_clr) begin
        if (stub_q.size() > 0) cur = stub_q.pop_front();
        else begin
          total++; bad++;
          $display("FAIL clr_without_accept: got bdu_clr=1 want 0");
        end
        s = 0; d = 0; was = 1'b0;
        bdu_terminate = 1'b0; bdu_done = 1'b0;
      end else if (bdu_valid) begin
        k = s / 3;
        co = s % 3;
        qb = (co == 0) ? cur.qx[B-1-k] : (co == 1) ? cur.qy[B-1-k] : cur.qz[B-1-k];
        rb = (co == 0) ? cur.rx[B-1-k] : (co == 1) ? cur.ry[B-1-k] : cur.rz[B-1-k];
        want = {qb, rb, 2'(co + 1), KW'((k + 1) % B), cur.thr};
        chk("stream_bit", {bdu_q_bit, bdu_r_bit, bdu_code, bdu_b, bdu_threshold}, want);
        bdu_terminate = (s == cur.term_at);
        bdu_done = 1'b0;
        bdu_dist = cur.base + B'(s);
        s++;
        was = 1'b1;
      end else begin
        if (was) begin
          chk("stream_length", s, cur.e_nbits);
          was = 1'b0;
        end
        chk("code_not_streaming", bdu_code, 2'd0);
        if (busy && !res_valid) begin
          bdu_dist = cur.base + B'(T + d);
          bdu_terminate = cur.drain_term && (d == cur.done_delay);
          bdu_done = !cur.drain_term && (d >= cur.done_delay);
          d++;
        end else begin
          bdu_terminate = 1'b0;
          bdu_done = 1'b0;
        end
      end
    end
  end

  // Result monitor: pops the scoreboard and drives res_ready backpressure
  initial begin
    int stall;
    bit seen, idle_chk;
    pt_t e;
    stall = 0; seen = 1'b0; idle_chk = 1'b0;
    forever @(negedge clk) begin
      if (!rst) begin
        res_ready = 1'b0;
      end else begin
        if (idle_chk) begin
          chk("idle_after_handshake", busy, 1'b0);
          idle_chk = 1'b0;
        end
        if (res_valid) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_result: got res_valid=1 want 0");
            res_ready = 1'b1;
          end else begin
            e = exp_q[0];
            if (!seen) begin
              seen = 1'b1;
              chk("res_latency", cyc - e.acc_cyc, e.e_lat);
              stall = e.stall ? 5 : int'($urandom_range(0, 2));
            end
            chk("res_idx", res_idx, e.idx);
            chk("res_dist", res_dist, e.e_dist);
            chk("res_pruned", res_pruned, e.e_pruned);
            chk("ref_ready_in_result", ref_ready, 1'b0);
            if (stall == 0) begin
              res_ready = 1'b1;
              void'(exp_q.pop_front());
              seen = 1'b0;
              idle_chk = 1'b1;
            end else begin
              res_ready = 1'b0;
              stall--;
            end
          end
        end else begin
          res_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    #800000;
    abort_run("watchdog");
  end

  initial begin
    pt_t p;
    int sel;
    rst = 1'b0; q_load = 1'b0; q_x = '0; q_y = '0; q_z = '0; thr_in = '0;
    ref_valid = 1'b0; ref_x = '0; ref_y = '0; ref_z = '0; ref_idx = '0;
    mqx = '0; mqy = '0; mqz = '0; mthr = '0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {ref_ready, busy, res_valid, res_idx, res_dist, res_pruned, bdu_clr,
                            bdu_valid, bdu_q_bit, bdu_r_bit, bdu_code, bdu_b, bdu_threshold}, '0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("ready_before_load", ref_ready, 1'b0);
    chk("busy_after_reset", busy, 1'b0);
    q_load = 1'b1; q_x = 32'h0000FFFF; q_y = '0; q_z = '0; thr_in = 32'h1234;
    mqx = q_x; mqy = q_y; mqz = q_z; mthr = thr_in;
    #1;
    chk("ready_during_load", ref_ready, 1'b0);
    @(negedge clk);
    q_load = 1'b0;
    #1;
    chk("ready_after_load", ref_ready, 1'b1);

    p = rand_pt();
    p.rx = 32'h0000FFF0; p.ry = '0; p.rz = '0; p.idx = 16'd5;
    p.term_at = NO_TERM; p.done_delay = 0; p.drain_term = 1'b0; p.stall = 1'b0;
    p.base = 32'hE1 - 32'd96;
    send_point(p, 1'b0, 1'b0);

    p = rand_pt();
    p.idx = 16'd6; p.term_at = 10; p.done_delay = 0; p.drain_term = 1'b0; p.stall = 1'b0;
    p.base = 32'h200 - 32'd10;
    send_point(p, 1'b0, 1'b0);

    p = rand_pt();
    p.stall = 1'b1;
    send_point(p, 1'b0, 1'b0);

    wait_idle();
    p = rand_pt();
    send_point(p, 1'b1, 1'b0);

    p = rand_pt();
    p.term_at = NO_TERM;
    send_point(p, 1'b0, 1'b1);

    for (int i = 0; i < 30; i++) begin
      p = rand_pt();
      sel = int'($urandom_range(0, 9));
      if (sel < 4) wait_idle();
      if (sel < 3) load_query(B'($urandom), B'($urandom), B'($urandom), B'($urandom));
      send_point(p, sel == 3, $urandom_range(0, 1) == 1);
    end

    wait_idle();
    repeat (5) @(negedge clk);
    chk("final_idle", busy, 1'b0);
    chk("final_stub_queue", stub_q.size(), 0);
    finish_run();
  end

endmodule
